// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues 1-cycle-latency imem reads, and hands {opcode, lit, pc}
// to the decoder through a 2-entry FIFO so one instruction per cycle survives backpressure.
module instr_fetch #(
  parameter int          PC_W     = 8,
  parameter int          K_W      = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_rd_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [K_W+6:0]    imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [6:0]        opcode,
  output logic [K_W-1:0]    lit,
  output logic [PC_W-1:0]   pc_out,
  input  logic              jump_en,
  input  logic [PC_W-1:0]   jump_target,
  input  logic              halt
);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [K_W-1:0]  lit;
    logic [PC_W-1:0] pc;
  } entry_t;

  state_t          state, state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_pc;
  logic            inflight;
  logic [1:0]      occ;
  entry_t          head, tail, fetched;
  logic            pop, push, discard, issue;
  logic [2:0]      load;

  // Handshake: the head entry transfers on a cycle where instr_valid & instr_ready are both 1;
  // instr_valid never depends on instr_ready, and the head holds stable until taken.
  assign instr_valid = (occ != 2'd0);
  assign pop         = instr_valid & instr_ready;
  assign discard     = inflight & jump_en;
  assign push        = inflight & ~discard;
  assign load        = 3'(occ) + 3'(inflight) - 3'(pop);
  assign fetched     = '{opcode: imem_rdata[K_W+6:K_W], lit: imem_rdata[K_W-1:0], pc: req_pc};

  assign opcode = head.opcode;
  assign lit    = head.lit;
  assign pc_out = head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // rst_n gating keeps the request low while reset is held, not just after the edge.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    imem_rd_en = 1'b0;
    imem_addr  = '0;
    case (state)
      RUN:    if (halt) state_next = HALTED;
      HALTED: if (!halt) state_next = RUN;
      default: state_next = RUN;
    endcase
    if (rst_n && state == RUN && !halt && !jump_en && load <= 3'd1) begin
      issue      = 1'b1;
      imem_rd_en = 1'b1;
      imem_addr  = pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= PC_W'(RESET_PC);
      req_pc   <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= issue;
      if (issue) req_pc <= pc;
      if (jump_en) begin
        pc <= jump_target;
      end else if (issue) begin
        pc <= pc + PC_W'(1);
      end
      if (jump_en) begin
        occ <= 2'd0;
      end else begin
        case ({push, pop})
          2'b11: begin
            if (occ == 2'd2) begin
              head <= tail;
              tail <= fetched;
            end else begin
              head <= fetched;
            end
          end
          2'b01: begin
            head <= tail;
            occ  <= occ - 2'd1;
          end
          2'b10: begin
            if (occ == 2'd0) head <= fetched;
            else             tail <= fetched;
            occ <= occ + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: startup latency, backpressure, jumps, halt, reset, and
// PC wrap on a 4-bit-PC instance; accepted instructions are scored against an expected queue.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        imem_rd_en, instr_valid, instr_ready, jump_en, halt;
  logic [7:0]  imem_addr, pc_out, jump_target, lit;
  logic [14:0] imem_rdata;
  logic [6:0]  opcode;

  logic        imem_rd_en4, instr_valid4;
  logic [3:0]  imem_addr4, pc_out4;
  logic [14:0] imem_rdata4;
  logic [6:0]  opcode4;
  logic [7:0]  lit4;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_e, exp_lit;
  int          cyc4;
  logic [3:0]  exp4;
  logic        got;

  instr_fetch #(.PC_W(8), .K_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .lit(lit), .pc_out(pc_out), .jump_en(jump_en),
    .jump_target(jump_target), .halt(halt)
  );

  instr_fetch #(.PC_W(4), .K_W(8), .RESET_PC(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .imem_rd_en(imem_rd_en4), .imem_addr(imem_addr4),
    .imem_rdata(imem_rdata4), .instr_valid(instr_valid4), .instr_ready(1'b1),
    .opcode(opcode4), .lit(lit4), .pc_out(pc_out4), .jump_en(1'b0),
    .jump_target(4'h0), .halt(1'b0)
  );

  function automatic logic [14:0] rom(input logic [7:0] a);
    rom = {a[6:0], a + 8'd1};
  endfunction

  always @(posedge clk) begin
    if (imem_rd_en)  imem_rdata  <= rom(imem_addr);
    if (imem_rd_en4) imem_rdata4 <= rom({4'h0, imem_addr4});
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted instruction must be the next expected address.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra", {24'h0, pc_out}, 32'hdead);
      end else begin
        exp_e   = exp_q.pop_front();
        exp_lit = exp_e + 8'd1;
        check("sb_pc", pc_out, exp_e);
        check("sb_opcode", opcode, exp_e[6:0]);
        check("sb_lit", lit, exp_lit);
      end
    end
  end

  // 4-bit PC instance streams from reset: valid every cycle from cycle 2, wrapping 15 -> 0.
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc4 = 0;
      exp4 = 4'h0;
    end else begin
      if (cyc4 >= 2 && cyc4 <= 25) begin
        check("wrap_valid", instr_valid4, 1);
        check("wrap_pc", pc_out4, exp4);
        check("wrap_opcode", opcode4, {3'b000, exp4});
        exp4 = exp4 + 4'd1;
      end
      cyc4++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr_ready = 1'b1; halt = 1'b0; jump_en = 1'b0; jump_target = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    check("rst_rd_en", imem_rd_en, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_opcode", opcode, 0);
    check("rst_lit", lit, 0);
    check("rst_pc_out", pc_out, 0);
    for (int i = 0; i < 48; i++) exp_q.push_back(8'(i));

    tick(); rst_n = 1'b1; #1;
    check("c0_rd_en", imem_rd_en, 1);
    check("c0_addr", imem_addr, 0);
    tick(); #1;
    check("c1_addr", imem_addr, 1);
    check("c1_valid", instr_valid, 0);
    tick(); #1;
    check("c2_valid", instr_valid, 1);
    check("c2_pc", pc_out, 0);
    check("c2_lit", lit, 1);
    tick();
    tick(); instr_ready = 1'b0; #1;
    check("bp_pc_first", pc_out, 2);
    check("bp_rd_en_first", imem_rd_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("bp_valid", instr_valid, 1);
      check("bp_pc", pc_out, 2);
      check("bp_opcode", opcode, 2);
      check("bp_rd_en", imem_rd_en, 0);
    end
    tick(); instr_ready = 1'b1; #1;
    check("bp_release_addr", imem_addr, 4);
    check("bp_release_pc", pc_out, 2);
    tick(); #1;
    check("bp_next_pc", pc_out, 3);
    tick(); #1;
    check("bp_next2_pc", pc_out, 4);

    tick(); instr_ready = 1'b0; jump_en = 1'b1; jump_target = 8'h40; #1;
    check("jmp_rd_en", imem_rd_en, 0);
    check("jmp_head", pc_out, 5);
    tick(); instr_ready = 1'b1; jump_en = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(8'(8'h40 + i));
    #1;
    check("jmp_valid_low", instr_valid, 0);
    check("jmp_rd_en_next", imem_rd_en, 1);
    check("jmp_addr_next", imem_addr, 8'h40);
    tick(); #1;
    check("jmp_valid_low2", instr_valid, 0);
    check("jmp_addr2", imem_addr, 8'h41);
    tick(); #1;
    check("jmp_first_valid", instr_valid, 1);
    check("jmp_first_pc", pc_out, 8'h40);

    tick(); jump_en = 1'b1; jump_target = 8'h80; #1;
    check("b2b_head", pc_out, 8'h41);
    check("b2b_rd_en", imem_rd_en, 0);
    tick(); jump_target = 8'h20; #1;
    check("b2b_valid_low", instr_valid, 0);
    tick(); jump_en = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(8'(8'h20 + i));
    #1;
    check("b2b_addr", imem_addr, 8'h20);
    tick(); #1;
    check("b2b_addr2", imem_addr, 8'h21);
    tick(); #1;
    check("b2b_first_pc", pc_out, 8'h20);

    tick(); halt = 1'b1; #1;
    check("halt_rd_en", imem_rd_en, 0);
    check("halt_head", pc_out, 8'h21);
    tick(); #1;
    check("halt_drain_valid", instr_valid, 1);
    check("halt_drain_pc", pc_out, 8'h22);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("halt_empty", instr_valid, 0);
      check("halt_idle", imem_rd_en, 0);
    end
    tick(); halt = 1'b0; #1;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      if (imem_rd_en) begin
        got = 1'b1;
        check("resume_addr", imem_addr, 8'h23);
      end else begin
        tick(); #1;
      end
    end
    check("resume_seen", got, 1);
    repeat (6) tick();

    rst_n = 1'b0; #1;
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_rd_en", imem_rd_en, 0);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_pc_out", pc_out, 0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    tick(); tick(); rst_n = 1'b1; #1;
    check("restart_rd_en", imem_rd_en, 1);
    check("restart_addr", imem_addr, 0);
    tick(); #1;
    check("restart_addr2", imem_addr, 1);
    tick(); #1;
    check("restart_valid", instr_valid, 1);
    check("restart_pc", pc_out, 0);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
